// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data RAM between the CPU data port
// and an external loader/debug port. The grant decision is combinational
// from the requests plus registered state. Read data is returned one cycle
// after the grant to whichever requester issued the read. External
// requesters may lock the RAM for bursts of up to MAX_BURST grants.
//
// Build option: define DMEM_ARB_AGING_EN to add a wait counter that promotes
// a starved external requester above the CPU for one grant after MAX_WAIT
// consecutive denied cycles. Without it the CPU has strict priority in IDLE.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8,
    parameter int MAX_WAIT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    // CPU data port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    // external loader/debug port
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic              ext_lock,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    // RAM port
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] LP_MAX_BURST = 8'(MAX_BURST);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } owner_t;

    state_t     r_state;
    logic [7:0] r_burst_cnt;
    owner_t     r_rd_owner;

    logic w_promoted;
    logic w_burst_hold;
    logic w_max_exit;
    logic w_ext_win;
    logic w_ext_gnt;
    logic w_cpu_gnt;

`ifdef DMEM_ARB_AGING_EN
    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    logic [7:0] r_wait_cnt;

    // Count consecutive denied external cycles, saturating; a grant clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= 8'd0;
        end else if (w_ext_gnt) begin
            r_wait_cnt <= 8'd0;
        end else if (ext_req && (r_wait_cnt < LP_MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    assign w_promoted = (r_wait_cnt >= LP_MAX_WAIT);
`else
    assign w_promoted = 1'b0;
`endif

    // Pick the winner: a live locked burst beats everything, otherwise the
    // CPU wins unless it is idle or the external port has been promoted.
    // The cycle that ends a full-length burst never honours promotion so
    // the waiting CPU always gets the next slot.
    always_comb begin
        w_burst_hold = (r_state == ST_BURST) && ext_req && ext_lock &&
                       (r_burst_cnt < LP_MAX_BURST);
        w_max_exit   = (r_state == ST_BURST) && (r_burst_cnt >= LP_MAX_BURST);
        w_ext_win    = w_burst_hold ||
                       (ext_req && (!cpu_req || (w_promoted && !w_max_exit)));
        w_ext_gnt    = w_ext_win;
        w_cpu_gnt    = cpu_req && !w_ext_win;
    end

    // Steer the winner onto the RAM port; park everything at zero when idle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_ext_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end else if (w_cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    // Burst state machine and read-return owner tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_burst_cnt <= 8'd0;
            r_rd_owner  <= OWN_NONE;
        end else begin
            if (w_burst_hold) begin
                r_state     <= ST_BURST;
                r_burst_cnt <= r_burst_cnt + 8'd1;
            end else if (w_ext_gnt && ext_lock) begin
                r_state     <= ST_BURST;
                r_burst_cnt <= 8'd1;
            end else begin
                r_state     <= ST_IDLE;
                r_burst_cnt <= 8'd0;
            end

            if (w_cpu_gnt && !cpu_we) begin
                r_rd_owner <= OWN_CPU;
            end else if (w_ext_gnt && !ext_we) begin
                r_rd_owner <= OWN_EXT;
            end else begin
                r_rd_owner <= OWN_NONE;
            end
        end
    end

    assign cpu_stall  = cpu_req && !w_cpu_gnt;
    assign ext_gnt    = w_ext_gnt;
    assign cpu_rvalid = (r_rd_owner == OWN_CPU);
    assign ext_rvalid = (r_rd_owner == OWN_EXT);
    assign cpu_rdata  = mem_rdata;
    assign ext_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter (MAX_BURST=8, MAX_WAIT=4).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        ext_req, ext_we, ext_lock;
    logic [31:0] ext_addr, ext_wdata;
    logic        ext_gnt, ext_rvalid;
    logic [31:0] ext_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:255];
    bit          ram_wr [0:255];

    int n_vec  = 0;
    int n_miss = 0;

    dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_BURST(8), .MAX_WAIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_gnt(ext_gnt),
        .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM: unwritten word i reads 0xA000_0000+i, except word 4 (0x10) reads 2.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr[9:2]]    <= mem_wdata;
                ram_wr[mem_addr[9:2]] <= 1'b1;
            end else if (ram_wr[mem_addr[9:2]]) begin
                mem_rdata <= ram[mem_addr[9:2]];
            end else if (mem_addr[9:2] == 8'd4) begin
                mem_rdata <= 32'h0000_0002;
            end else begin
                mem_rdata <= 32'hA000_0000 + 32'(mem_addr[9:2]);
            end
        end
    end

    task automatic clear_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_lock = 1'b0;
        ext_addr = '0; ext_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        #1;
        n_vec++;
        if ({cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, mem_en, mem_we} !== 6'b0) begin
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, mem_en, mem_we});
            n_miss++;
        end
        n_vec++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            $display("FAIL reset_mem: addr %h wdata %h expected 0 0", mem_addr, mem_wdata);
            n_miss++;
        end
        @(posedge clk); #1;
        n_vec++;
        if ({cpu_rvalid, ext_rvalid} !== 2'b00) begin
            $display("FAIL reset_rvalid: got %b expected 00", {cpu_rvalid, ext_rvalid});
            n_miss++;
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_cpu_read();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        #1;
        n_vec++;
        if ({mem_en, mem_we, cpu_stall} !== 3'b100 || mem_addr !== 32'h10) begin
            $display("FAIL cpu_read_gnt: en/we/stall %b addr %h expected 100 00000010",
                     {mem_en, mem_we, cpu_stall}, mem_addr);
            n_miss++;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_vec++;
        if ({cpu_rvalid, ext_rvalid} !== 2'b10) begin
            $display("FAIL cpu_read_rvalid: got %b expected 10", {cpu_rvalid, ext_rvalid});
            n_miss++;
        end
        n_vec++;
        if (cpu_rdata !== 32'h0000_0002) begin
            $display("FAIL cpu_read_data: got %h expected 00000002", cpu_rdata);
            n_miss++;
        end
        n_vec++;
        if (mem_en !== 1'b0 || mem_addr !== 32'h0) begin
            $display("FAIL idle_mem: en %b addr %h expected 0 0", mem_en, mem_addr);
            n_miss++;
        end
    endtask

    task automatic test_cpu_write();
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h3;
        #1;
        n_vec++;
        if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 32'h20 || mem_wdata !== 32'h3) begin
            $display("FAIL cpu_write: en/we %b addr %h wdata %h expected 11 00000020 00000003",
                     {mem_en, mem_we}, mem_addr, mem_wdata);
            n_miss++;
        end
        @(negedge clk);
        cpu_we = 1'b0; cpu_wdata = '0;
        #1;
        n_vec++;
        if ({cpu_rvalid, ext_rvalid} !== 2'b00) begin
            $display("FAIL write_no_rvalid: got %b expected 00", {cpu_rvalid, ext_rvalid});
            n_miss++;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_vec++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h3) begin
            $display("FAIL write_readback: rvalid %b data %h expected 1 00000003",
                     cpu_rvalid, cpu_rdata);
            n_miss++;
        end
    endtask

    task automatic test_conflict();
        logic exp_gnt;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
            ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h24; ext_lock = 1'b0;
            #1;
`ifdef DMEM_ARB_AGING_EN
            exp_gnt = (k == 4);
`else
            exp_gnt = 1'b0;
`endif
            n_vec++;
            if (ext_gnt !== exp_gnt || cpu_stall !== exp_gnt) begin
                $display("FAIL conflict_c%0d: gnt/stall %b%b expected %b%b",
                         k, ext_gnt, cpu_stall, exp_gnt, exp_gnt);
                n_miss++;
            end
            if (k > 0) begin
                n_vec++;
                if (cpu_rvalid !== 1'b1) begin
                    $display("FAIL conflict_rvalid_c%0d: got %b expected 1", k, cpu_rvalid);
                    n_miss++;
                end
            end
        end
        // CPU still held: external must not win again back to back
        @(negedge clk);
        #1;
        n_vec++;
        if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
            $display("FAIL conflict_c5: gnt/stall %b%b expected 00", ext_gnt, cpu_stall);
            n_miss++;
        end
        // CPU drops: lone external request granted at once
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        n_vec++;
        if (ext_gnt !== 1'b1 || mem_addr !== 32'h24) begin
            $display("FAIL conflict_lone_ext: gnt %b addr %h expected 1 00000024",
                     ext_gnt, mem_addr);
            n_miss++;
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_vec++;
        if ({cpu_rvalid, ext_rvalid} !== 2'b01 || ext_rdata !== 32'hA000_0009) begin
            $display("FAIL conflict_ext_rd: rvalid %b data %h expected 01 a0000009",
                     {cpu_rvalid, ext_rvalid}, ext_rdata);
            n_miss++;
        end
    endtask

    task automatic test_burst();
        int   ext_idx  = 0;
        int   exp_idx  = 0;
        bit   cpu_pend = 1'b1;
        logic prev_gnt = 1'b0;
        logic exp_gnt, exp_stall;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            ext_req  = (ext_idx < 10);
            ext_lock = ext_req;
            ext_we   = 1'b0;
            ext_addr = 32'h40 + 32'(4 * ext_idx);
            cpu_req  = (c >= 1) && cpu_pend;
            cpu_we   = 1'b0;
            cpu_addr = 32'h10;
            #1;
            exp_gnt   = (c <= 7) || (c == 9) || (c == 10);
            exp_stall = (c >= 1) && (c <= 7);
            n_vec++;
            if (ext_gnt !== exp_gnt || cpu_stall !== exp_stall) begin
                $display("FAIL burst_c%0d: gnt/stall %b%b expected %b%b",
                         c, ext_gnt, cpu_stall, exp_gnt, exp_stall);
                n_miss++;
            end
            n_vec++;
            if (ext_rvalid !== prev_gnt) begin
                $display("FAIL burst_rvalid_c%0d: got %b expected %b", c, ext_rvalid, prev_gnt);
                n_miss++;
            end
            if (prev_gnt) begin
                n_vec++;
                if (ext_rdata !== 32'hA000_0010 + 32'(exp_idx - 1)) begin
                    $display("FAIL burst_data_c%0d: got %h expected %h",
                             c, ext_rdata, 32'hA000_0010 + 32'(exp_idx - 1));
                    n_miss++;
                end
            end
            if (c == 8) begin
                n_vec++;
                if (mem_addr !== 32'h10) begin
                    $display("FAIL burst_cpu_slot: addr %h expected 00000010", mem_addr);
                    n_miss++;
                end
            end
            if (c == 9) begin
                n_vec++;
                if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h2) begin
                    $display("FAIL burst_cpu_rd: rvalid %b data %h expected 1 00000002",
                             cpu_rvalid, cpu_rdata);
                    n_miss++;
                end
            end
            if (ext_gnt) ext_idx++;
            if (cpu_req && !cpu_stall) cpu_pend = 1'b0;
            if (exp_gnt) exp_idx++;
            prev_gnt = exp_gnt;
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            clear_inputs();
            cpu_req  = (c < 2);
            cpu_addr = 32'h40 + 32'(4 * c);
            ext_req  = (c == 2) || (c == 3);
            ext_addr = 32'h40 + 32'(4 * c);
            #1;
            if (c < 4) begin
                n_vec++;
                if (cpu_stall !== 1'b0 || ext_gnt !== ext_req || mem_addr !== 32'h40 + 32'(4 * c)) begin
                    $display("FAIL b2b_gnt_c%0d: stall %b gnt %b addr %h expected 0 %b %h",
                             c, cpu_stall, ext_gnt, mem_addr, ext_req, 32'h40 + 32'(4 * c));
                    n_miss++;
                end
            end
            if (c > 0) begin
                n_vec++;
                if (cpu_rvalid !== (c <= 2) || ext_rvalid !== (c >= 3) ||
                    cpu_rdata !== 32'hA000_0010 + 32'(c - 1)) begin
                    $display("FAIL b2b_rd_c%0d: rvalid %b%b data %h expected %b%b %h",
                             c, cpu_rvalid, ext_rvalid, cpu_rdata, (c <= 2), (c >= 3),
                             32'hA000_0010 + 32'(c - 1));
                    n_miss++;
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        ext_req = 1'b1; ext_lock = 1'b1; ext_we = 1'b0; ext_addr = 32'h44;
        #1;
        n_vec++;
        if (ext_gnt !== 1'b1) begin
            $display("FAIL midrst_gnt0: got %b expected 1", ext_gnt);
            n_miss++;
        end
        @(negedge clk);
        ext_addr = 32'h48;
        #1;
        n_vec++;
        if (ext_gnt !== 1'b1 || ext_rvalid !== 1'b1) begin
            $display("FAIL midrst_gnt1: gnt/rvalid %b%b expected 11", ext_gnt, ext_rvalid);
            n_miss++;
        end
        #2;
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        #1;
        n_vec++;
        if ({cpu_rvalid, ext_rvalid, ext_gnt, mem_en, mem_we} !== 5'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            $display("FAIL midrst_drop: ctrl %b addr %h wdata %h expected 00000 0 0",
                     {cpu_rvalid, ext_rvalid, ext_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
            n_miss++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'h10;
        ext_req = 1'b1; ext_lock = 1'b1; ext_addr = 32'h4C;
        #1;
        n_vec++;
        if (ext_gnt !== 1'b0 || cpu_stall !== 1'b0) begin
            $display("FAIL midrst_idle: gnt/stall %b%b expected 00", ext_gnt, cpu_stall);
            n_miss++;
        end
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        n_vec++;
        if (ext_gnt !== 1'b1 || cpu_rvalid !== 1'b1) begin
            $display("FAIL midrst_resume: gnt/cpu_rvalid %b%b expected 11", ext_gnt, cpu_rvalid);
            n_miss++;
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_conflict();
        test_burst();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-port data memory between the CPU data port (address from ALU result, write data from RD2, write enable from MemWrite) and an external loader/debug port. It sits between the CPU core and the data RAM and stalls the CPU while the external port owns the memory. It also routes one-cycle-latency read data back to the requester that issued the read. External requesters may lock the memory for bounded bursts, and an optional aging counter prevents loader starvation.

## Interface
- ADDR_W, 32: byte address width on all ports.
- DATA_W, 32: data width.
- MAX_BURST, 8: maximum consecutive locked external grants, 1..255.
- MAX_WAIT, 4: consecutive denied external cycles before external is promoted, 1..255 (used only with aging).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  CPU data access request.
- cpu_we  in  1  CPU write (MemWrite).
- cpu_addr  in  ADDR_W  CPU address (ALU result).
- cpu_wdata  in  DATA_W  CPU write data (RD2).
- cpu_stall  out  1  CPU must hold request and freeze.
- cpu_rvalid  out  1  cpu_rdata valid.
- cpu_rdata  out  DATA_W  read data to CPU (ReadData).
- ext_req, ext_we, ext_lock  in  1 each  external request, write, burst lock.
- ext_addr  in  ADDR_W  external address.
- ext_wdata  in  DATA_W  external write data.
- ext_gnt  out  1  external access accepted this cycle.
- ext_rvalid  out  1  ext_rdata valid.
- ext_rdata  out  DATA_W  read data to external port.
- mem_en, mem_we  out  1 each  RAM enable and write.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read enable.

## Operation
- The grant decision is combinational from the requests and registered state. The mem_* signals are muxed from the winner in the same cycle.
- When no request is granted, mem_en=0, mem_we=0, and mem_addr and mem_wdata are 0.
- Requesters hold the request and all request fields stable until it is accepted. CPU acceptance is cpu_req && !cpu_stall. External acceptance is ext_gnt.
- cpu_stall = cpu_req && !cpu_gnt. ext_gnt = ext_req && ext won.
- FSM states:
  - IDLE: on a conflict, CPU wins. External wins if the CPU is idle, or if promoted (aging). A granted ext access with ext_lock=1 moves to BURST with burst_cnt=1.
  - BURST: external wins unconditionally while ext_req && ext_lock. burst_cnt increments per grant.
  - BURST exit to IDLE: when ext_req=0, ext_lock=0, or burst_cnt==MAX_BURST. On exit at MAX_BURST with cpu_req=1, the CPU is guaranteed the next cycle.
- rd_owner register {NONE, CPU, EXT} is set on each granted read, and set to NONE otherwise.
- Next cycle, the selected rvalid is 1. Both rdata outputs always carry mem_rdata.
- Writes produce no rvalid.

## Timing
- Reset values: state=IDLE, burst_cnt=0, wait_cnt=0, rd_owner=NONE, cpu_rvalid=0, ext_rvalid=0.
- With no requests during reset, all combinational outputs are 0.
- Read latency: grant cycle N gives rvalid in cycle N+1. Back-to-back reads from either requester are sustained at 1 per cycle.
- Reset asserted mid-operation: any pending read is dropped (no rvalid) and a burst is aborted. Requesters reissue after reset.
- Simultaneous requests in IDLE: CPU granted unless promoted. External is never granted two cycles in a row outside BURST while cpu_req is held.
- A lone request is granted with zero added latency.

## Configuration
- DMEM_ARB_AGING_EN defined:
  - wait_cnt increments each cycle ext_req=1 && !ext_gnt. It saturates at MAX_WAIT and clears on ext_gnt.
  - In IDLE, wait_cnt==MAX_WAIT gives external priority over the CPU for one grant.
- DMEM_ARB_AGING_EN undefined:
  - No wait_cnt register.
  - CPU has strict priority in IDLE. External is served only when the CPU is idle, or in BURST already entered.

## Test plan
- CPU read to 0x10 with RAM returning 0x0000_0002 -> mem_en=1, mem_we=0, cpu_stall=0; next cycle cpu_rvalid=1, cpu_rdata=0x0000_0002, ext_rvalid=0.
- CPU write 0x3 to 0x20 while ext idle -> mem_we=1, mem_addr=0x20, mem_wdata=0x3, no rvalid.
- Both request in IDLE, aging off, CPU held 5 cycles -> cpu granted 5 cycles, ext_gnt=0 throughout.
- Same with aging on, MAX_WAIT=4 -> ext_gnt=1 in cycle 5, cpu_stall=1 that cycle only.
- ext_lock burst of 10 reads with MAX_BURST=8 and cpu_req=1 -> 8 ext grants, then 1 CPU grant, then ext resumes; ext_rvalid follows each grant by one cycle.
- rst low one cycle after an ext read grant -> ext_rvalid stays 0, state=IDLE, all mem_* 0 until a new request.
